ps2_rx_frame: RTL

Receive-only PS/2 front end feeding the SuperIO keyboard register block.
- Samples the raw PS/2 clock/data lines, filters clock glitches, deserialises 11-bit frames and checks parity/stop.
- Folds E0 (extended) and F0 (release) prefix bytes into flags on the following scancode.
- Presents each scancode through a single-entry ready/read handshake, which the bus-side register block consumes with a one-cycle read strobe.

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_clk_filter.sv | 58 +++++
 rtl/ps2_rx_frame.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 receive path shared definitions.
// Prefix byte values and frame FSM encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line synchroniser and clock glitch filter.
// Emits one pulse per filtered falling clock edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2clk,
  input  logic ps2dat,
  output logic dat_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    clk_sr;
  logic [1:0]    dat_sr;
  logic [CW-1:0] cnt;
  logic          clk_s;
  logic          clk_filt;
  logic          flip;

  assign clk_s    = clk_sr[1];
  assign dat_sync = dat_sr[1];
  assign flip     = (clk_s != clk_filt) &&
                    (cnt == CW'(FILTER_LEN - 1));

  // two-flop synchronisers, idle lines read high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr <= 2'b11;
      dat_sr <= 2'b11;
    end else begin
      clk_sr <= {clk_sr[0], ps2clk};
      dat_sr <= {dat_sr[0], ps2dat};
    end
  end

  // level changes only after a full run of differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      clk_filt <= 1'b1;
      fall     <= 1'b0;
    end else begin
      fall <= flip & clk_filt;
      if (clk_s == clk_filt) begin
        cnt <= '0;
      end else if (flip) begin
        cnt      <= '0;
        clk_filt <= clk_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer with prefix folding.
// Single-entry ready/read output holding register.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2dat,
  input  logic       rx_read,
  output logic [7:0] rx_scan_code,
  output logic       rx_extended,
  output logic       rx_released,
  output logic       rx_data_ready,
  output logic       rx_overrun,
  output logic       rx_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t    state;
  ps2_state_t    state_nx;
  logic          dat_s;
  logic          fall;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          start_bit;
  logic          shift_en;
  logic          par_en;
  logic          frame_end;
  logic          frame_ok;
  logic          err_now;
  logic          is_ext;
  logic          is_rel;
  logic          load;
  logic          read_ack;
  logic          ext_pend;
  logic          rel_pend;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk     (clk),
    .rst     (rst),
    .ps2clk  (ps2clk),
    .ps2dat  (ps2dat),
    .dat_sync(dat_s),
    .fall    (fall)
  );

  assign timeout  = (state != ST_IDLE) &&
                    (to_cnt == TW'(TIMEOUT_CYCLES));
  assign frame_ok = frame_end & (^{shreg, par}) & dat_s;
  assign err_now  = timeout | (frame_end & ~frame_ok);
  assign is_ext   = (shreg == PS2_PREFIX_EXT);
  assign is_rel   = (shreg == PS2_PREFIX_REL);
  assign load     = frame_ok & ~is_ext & ~is_rel;
  assign read_ack = rx_read & rx_data_ready;

  // frame state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // frame sequencing on sample events, timeout wins
  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = ST_IDLE;
    end else if (fall) begin
      unique case (state)
        ST_IDLE:   if (!dat_s) state_nx = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        ST_PARITY: state_nx = ST_STOP;
        ST_STOP:   state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // per-state datapath strobes
  always_comb begin
    start_bit = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      ST_IDLE:   start_bit = fall & ~dat_s;
      ST_DATA:   shift_en  = fall & ~timeout;
      ST_PARITY: par_en    = fall & ~timeout;
      ST_STOP:   frame_end = fall & ~timeout;
      default:   start_bit = 1'b0;
    endcase
  end

  // stall watchdog, idle or any sample event rearms it
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE || fall) to_cnt <= '0;
    else if (!timeout)                  to_cnt <= to_cnt + 1'b1;
  end

  // LSB-first shifter; bit counter saturates at 7
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
    end else begin
      if (start_bit) bit_cnt <= '0;
      if (shift_en) begin
        shreg <= {dat_s, shreg[7:1]};
        if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en) par <= dat_s;
    end
  end

  // prefix folding, holding register and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend      <= 1'b0;
      rel_pend      <= 1'b0;
      rx_scan_code  <= '0;
      rx_extended   <= 1'b0;
      rx_released   <= 1'b0;
      rx_data_ready <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      rx_error <= err_now;
      if (err_now) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (frame_ok) begin
        unique case (1'b1)
          is_ext: ext_pend <= 1'b1;
          is_rel: rel_pend <= 1'b1;
          default: begin
            rx_scan_code <= shreg;
            rx_extended  <= ext_pend;
            rx_released  <= rel_pend;
            ext_pend     <= 1'b0;
            rel_pend     <= 1'b0;
          end
        endcase
      end
      if (load)          rx_data_ready <= 1'b1;
      else if (read_ack) rx_data_ready <= 1'b0;
      if (read_ack)                   rx_overrun <= 1'b0;
      else if (load && rx_data_ready) rx_overrun <= 1'b1;
    end
  end

endmodule
